// File: rtl/alu_share_if.sv
// rtl/alu_share_if.sv - requester/response handshake bundle for the shared ALU arbiter
interface alu_share_if #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [31:0]        rsp_result;
    logic [2:0]         rsp_flags;
    logic [ID_W-1:0]    rsp_owner;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_owner
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_owner
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between NREQ requesters
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_share_if.slave  bus,
    output logic [3:0]  alu_ctrl_s,
    output logic [31:0] alu_rega,
    output logic [31:0] alu_regb,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     result_q, result_d;
    logic [2:0]      flags_q, flags_d;

    logic            win_found;
    logic [ID_W-1:0] win_idx;
    logic [ID_W:0]   idx_ext;
    logic [ID_W:0]   nxt_ext;

    // Scan requesters starting at rr_ptr, wrapping modulo NREQ; first valid wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_ext   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_ext = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_ext >= (ID_W+1)'(NREQ)) begin
                idx_ext = idx_ext - (ID_W+1)'(NREQ);
            end
            if (!win_found && bus.req_valid[idx_ext[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_ext[ID_W-1:0];
            end
        end
        nxt_ext = {1'b0, win_idx} + (ID_W+1)'(1);
        if (nxt_ext >= (ID_W+1)'(NREQ)) begin
            nxt_ext = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        result_d      = result_q;
        flags_d       = flags_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state_q)
            IDLE: begin
                // Grant is gated by rst_n so no ready leaks out while held in reset.
                if (win_found && rst_n) begin
                    bus.req_ready[win_idx] = 1'b1;
                    owner_d  = win_idx;
                    op_d     = bus.req_op[win_idx*4 +: 4];
                    a_d      = bus.req_a[win_idx*32 +: 32];
                    b_d      = bus.req_b[win_idx*32 +: 32];
                    rr_ptr_d = nxt_ext[ID_W-1:0];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                flags_d  = alu_flags;
                state_d  = RESP;
            end
            RESP: begin
                bus.rsp_valid[owner_q] = 1'b1;
                if (bus.rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign alu_ctrl_s     = op_q;
    assign alu_rega       = a_q;
    assign alu_regb       = b_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.rsp_owner  = owner_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed table-driven bench for alu_share_arbiter
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  alu_ctrl_s;
    logic [31:0] alu_rega, alu_regb, alu_result;
    logic [2:0]  alu_flags;
    logic        busy;

    always #5 clk = ~clk;

    alu_share_if #(.NREQ(2), .ID_W(1)) bus ();

    alu_share_arbiter #(.NREQ(2), .ID_W(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .alu_ctrl_s (alu_ctrl_s),
        .alu_rega   (alu_rega),
        .alu_regb   (alu_regb),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .busy       (busy)
    );

    // Reference ALU: 0 add, 1 and, 2 sub, 3 or, others 0/0; flags {zero,negative,overflow}.
    always_comb begin
        logic ovf;
        ovf = 1'b0;
        case (alu_ctrl_s)
            4'd0: begin
                alu_result = alu_rega + alu_regb;
                ovf = (alu_rega[31] == alu_regb[31]) && (alu_result[31] != alu_rega[31]);
            end
            4'd1: alu_result = alu_rega & alu_regb;
            4'd2: begin
                alu_result = alu_rega - alu_regb;
                ovf = (alu_rega[31] != alu_regb[31]) && (alu_result[31] != alu_rega[31]);
            end
            4'd3: alu_result = alu_rega | alu_regb;
            default: alu_result = 32'd0;
        endcase
        if (alu_ctrl_s > 4'd3) alu_flags = 3'b000;
        else alu_flags = {alu_result == 32'd0, alu_result[31], ovf};
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs[7];

    task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[id*4 +: 4]  = op;
        bus.req_a[id*32 +: 32] = a;
        bus.req_b[id*32 +: 32] = b;
    endtask

    task automatic do_op(input vec_t v);
        @(negedge clk);
        set_req(v.id, v.op, v.a, v.b);
        bus.req_valid = 2'(1 << v.id);
        bus.rsp_ready = 2'b00;
        #1;
        chk("grant", 32'(bus.req_ready), 32'(1 << v.id));
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("alu_op", 32'(alu_ctrl_s), 32'(v.op));
        chk("alu_a", alu_rega, v.a);
        chk("alu_b", alu_regb, v.b);
        @(negedge clk);
        #1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << v.id));
        chk("rsp_result", bus.rsp_result, v.res);
        chk("rsp_flags", 32'(bus.rsp_flags), 32'(v.flg));
        chk("rsp_owner", 32'(bus.rsp_owner), 32'(v.id));
        bus.rsp_ready = 2'(1 << v.id);
        @(negedge clk);
        #1;
        chk("back_idle", 32'(busy), 32'd0);
        chk("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        int g;
        int last_c;

        vecs[0] = '{0, 4'd0,  32'd7,          32'd5,      32'd12,         3'b000};
        vecs[1] = '{1, 4'd2,  32'h8000_0000,  32'd1,      32'h7FFF_FFFF,  3'b001};
        vecs[2] = '{0, 4'd0,  32'h7FFF_FFFF,  32'd1,      32'h8000_0000,  3'b011};
        vecs[3] = '{1, 4'd2,  32'd5,          32'd5,      32'd0,          3'b100};
        vecs[4] = '{0, 4'd1,  32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000, 3'b000};
        vecs[5] = '{0, 4'd3,  32'h8000_0000,  32'd1,      32'h8000_0001,  3'b010};
        vecs[6] = '{1, 4'd15, 32'd1234,       32'd5678,   32'd0,          3'b000};

        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", bus.rsp_result, 32'd0);
        chk("rst_alu_a", alu_rega, 32'd0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) do_op(vecs[i]);

        // Both requesters valid continuously: grants alternate, one handshake every 3 cycles.
        @(negedge clk);
        set_req(0, 4'd0, 32'd7, 32'd5);
        set_req(1, 4'd2, 32'h8000_0000, 32'd1);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        g = 0;
        last_c = -1;
        for (int c = 0; c < 40 && g < 4; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                chk("alt_grant", 32'(bus.req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
                if (last_c >= 0) chk("grant_spacing", 32'(c - last_c), 32'd3);
                last_c = c;
                g++;
            end
            if (bus.rsp_valid == 2'b10) begin
                chk("alt_res1", bus.rsp_result, 32'h7FFF_FFFF);
                chk("alt_flg1", 32'(bus.rsp_flags), 32'd1);
            end
            if (bus.rsp_valid == 2'b01) chk("alt_res0", bus.rsp_result, 32'd12);
            @(negedge clk);
        end
        chk("grant_count", 32'(g), 32'd4);
        bus.req_valid = 2'b00;
        repeat (4) @(negedge clk);
        bus.rsp_ready = 2'b00;

        // Owner withholds rsp_ready; non-owner ready and pending request must be ignored.
        @(negedge clk);
        set_req(0, 4'd0, 32'd100, 32'd23);
        bus.req_valid = 2'b01;
        #1;
        chk("hold_grant", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_result", bus.rsp_result, 32'd123);
            chk("hold_no_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        chk("post_hold_rr", 32'(bus.req_ready), 32'd2);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("drop_no_change", 32'(busy), 32'd0);
        bus.rsp_ready = 2'b00;

        // Reset during EXEC aborts the operation and restarts arbitration at requester 0.
        @(negedge clk);
        set_req(0, 4'd0, 32'd1, 32'd1);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("abort_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 32'd0);
        chk("abort_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rr0", 32'(bus.req_ready), 32'd1);
        chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("abort_idle_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
